// File: rtl/spi_flash_stream_fetch.sv
// SPI flash stream reader: single (0x03) or quad-output (0x6B) read from a 24-bit address,
// streaming bytes into a small FIFO for the pixel pipeline; SCLK pauses at byte boundaries when full.
module spi_flash_stream_fetch #(
    parameter int FIFO_DEPTH = 4,
    parameter int QUAD_DUMMY = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        quad,
    input  logic [23:0] addr,
    input  logic        stop,
    input  logic        pix_rd,
    output logic [7:0]  pix_data,
    output logic        pix_valid,
    output logic        busy,
    output logic        underrun,
    output logic        spi_cs,
    output logic        spi_sclk,
    output logic        spi_out0,
    output logic        spi_dir0,
    input  logic [3:0]  spi_in
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [4:0]       DUMMY_LAST = 5'(QUAD_DUMMY - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_ADDR  = 3'd2,
        S_DUMMY = 3'd3,
        S_DATA  = 3'd4
    } state_t;

    state_t           state;
    logic             phase;      // 0: sclk low half, 1: sclk high half
    logic [4:0]       bit_cnt;    // SCLKs left in the current segment, minus one
    logic [30:0]      tx_sr;      // command bits [6:0] followed by the address
    logic [6:0]       rx_sr;
    logic             quad_r;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             start_accept;
    logic             pop;
    logic             push;
    logic [CNT_W-1:0] count_after_pop;
    logic             can_issue;
    logic             byte_first;
    logic [7:0]       rx_next;
    logic [7:0]       cmd;

    // Pixel side: pix_data is the FIFO head and is meaningful while pix_valid=1;
    // a cycle with pix_valid=1 and pix_rd=1 pops exactly one byte, pix_rd with pix_valid=0 pops nothing.
    always_comb begin
        start_accept    = (state == S_IDLE) && start && !stop;
        cmd             = quad ? 8'h6B : 8'h03;
        pop             = pix_rd && (count != '0);
        count_after_pop = count - CNT_W'(pop);
        can_issue       = count_after_pop < DEPTH_C;
        byte_first      = (bit_cnt == (quad_r ? 5'd1 : 5'd7));
        rx_next         = quad_r ? {rx_sr[3:0], spi_in} : {rx_sr, spi_in[1]};
        push            = (state == S_DATA) && phase && (bit_cnt == 5'd0) && !stop;
    end

    assign pix_valid = (count != '0);
    assign pix_data  = pix_valid ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            phase    <= 1'b0;
            bit_cnt  <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            quad_r   <= 1'b0;
            spi_cs   <= 1'b0;
            spi_sclk <= 1'b0;
            spi_out0 <= 1'b0;
            spi_dir0 <= 1'b0;
            busy     <= 1'b0;
        end else if (stop && (state != S_IDLE)) begin
            state    <= S_IDLE;
            phase    <= 1'b0;
            spi_cs   <= 1'b0;
            spi_sclk <= 1'b0;
            spi_out0 <= 1'b0;
            spi_dir0 <= 1'b0;
            busy     <= 1'b0;
        end else if (state == S_IDLE) begin
            if (start_accept) begin
                quad_r   <= quad;
                tx_sr    <= {cmd[6:0], addr};
                spi_out0 <= cmd[7];
                spi_dir0 <= 1'b0;
                spi_cs   <= 1'b1;
                spi_sclk <= 1'b0;
                busy     <= 1'b1;
                phase    <= 1'b0;
                bit_cnt  <= 5'd7;
                state    <= S_CMD;
            end
        end else if (!phase) begin
            // Hold the low half of a byte's first SCLK until the FIFO has room for that byte.
            if (!((state == S_DATA) && byte_first && !can_issue)) begin
                phase    <= 1'b1;
                spi_sclk <= 1'b1;
            end
        end else begin
            phase    <= 1'b0;
            spi_sclk <= 1'b0;
            case (state)
                S_CMD, S_ADDR: begin
                    tx_sr    <= {tx_sr[29:0], 1'b0};
                    spi_out0 <= tx_sr[30];
                    if (bit_cnt != 5'd0) begin
                        bit_cnt <= bit_cnt - 5'd1;
                    end else if (state == S_CMD) begin
                        state   <= S_ADDR;
                        bit_cnt <= 5'd23;
                    end else begin
                        spi_out0 <= 1'b0;
                        if (quad_r) begin
                            state    <= S_DUMMY;
                            bit_cnt  <= DUMMY_LAST;
                            spi_dir0 <= 1'b1;
                        end else begin
                            state   <= S_DATA;
                            bit_cnt <= 5'd7;
                        end
                    end
                end
                S_DUMMY: begin
                    if (bit_cnt != 5'd0) begin
                        bit_cnt <= bit_cnt - 5'd1;
                    end else begin
                        state   <= S_DATA;
                        bit_cnt <= 5'd1;
                    end
                end
                S_DATA: begin
                    rx_sr <= rx_next[6:0];
                    if (bit_cnt != 5'd0) begin
                        bit_cnt <= bit_cnt - 5'd1;
                    end else begin
                        bit_cnt <= quad_r ? 5'd1 : 5'd7;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (start_accept) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun <= 1'b0;
        end else if (pix_rd && (count == '0)) begin
            underrun <= 1'b1;
        end else if (start_accept) begin
            underrun <= 1'b0;
        end
    end

endmodule
